// File: rtl/wishbone_master_pkg.sv
// Shared types and constants for the Wishbone command master.
// FSM state encoding, queued command record, CSR address map.
// No logic; imported by the master, its FIFO wrapper and benches.
package wishbone_master_pkg;

   localparam int WB_ADDR_W = 8;
   localparam int WB_DATA_W = 32;

   // MAC CSR byte addresses used by management software and benches
   localparam logic [WB_ADDR_W-1:0] CPUREG_CTRL        = 8'h00;
   localparam logic [WB_ADDR_W-1:0] CPUREG_SCRATCH     = 8'h04;
   localparam logic [WB_ADDR_W-1:0] CPUREG_INT_PENDING = 8'h08;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic                 we;
      logic [WB_ADDR_W-1:0] adr;
      logic [WB_DATA_W-1:0] dat;
   } cmd_t;

endpackage

// File: rtl/wishbone_master_if.sv
// Classic Wishbone single-cycle bus bundle between the master and a CSR slave.
// Pure wiring, no latency.
// Slave stalls the master by withholding wb_ack_i.
interface wishbone_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [DATA_W-1:0] wb_dat_i;
   logic              wb_ack_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/wishbone_master_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x WIDTH, head entry visible on rd_dat.
// Latency: write visible at the head one cycle after push.
// Backpressure: full blocks pushes; push and pop may coincide when not full.
module wb_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 41
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // extra pointer bit distinguishes full from empty
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_wr  = wr_vld && !full;
   assign do_rd  = rd_rdy && !empty;
   assign rd_dat = mem[rd_ptr[AW-1:0]];

   // storage array, no reset needed since empty flag masks stale data
   always_ff @(posedge wb_clk_i) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

   // pointer advance on accepted push/pop
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/wishbone_master.sv
// Queued command stream to single classic Wishbone cycles, one response per command.
// Latency: cmd accept -> stb 2 cycles; ack -> rsp_valid_o 1 cycle. One cycle outstanding.
// Backpressure: cmd_ready_o = FIFO not full; no new cycle while a response is pending.
// Optional macro WB_MASTER_TIMEOUT_EN adds an ack timeout that returns rsp_err_o=1.
module wishbone_master
   import wishbone_master_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_adr_i,
   input  logic [DATA_W-1:0] cmd_dat_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_we_o,
   output logic [DATA_W-1:0] rsp_dat_o,
   output logic              rsp_err_o,
   output logic              busy_o,
   wishbone_master_if.master wb
);
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
   } fifo_cmd_t;

   localparam int FW = $bits(fifo_cmd_t);

   fifo_cmd_t         push_cmd;
   fifo_cmd_t         head_cmd;
   logic [FW-1:0]     head_raw;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   state_e            state;
   logic              cyc_q;
   logic              we_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;
   logic              rsp_valid_q;
   logic              rsp_we_q;
   logic [DATA_W-1:0] rsp_dat_q;

   assign push_cmd = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i};
   assign head_cmd = fifo_cmd_t'(head_raw);
   assign fifo_pop = (state == IDLE) && !fifo_empty;

   wb_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .WIDTH (FW)
   ) u_cmd_fifo (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n_i (wb_rst_n_i),
      .wr_vld     (cmd_valid_i),
      .wr_dat     (push_cmd),
      .rd_rdy     (fifo_pop),
      .rd_dat     (head_raw),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int                TO_W    = (TIMEOUT_CYCLES > 255) ? 16 : 8;
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0]              to_cnt;
   logic                         rsp_err_q;
   logic                         to_hit;

   // last REQ cycle without ack; an ack in the same cycle takes priority
   assign to_hit    = (to_cnt == TO_LAST);
   assign rsp_err_o = rsp_err_q;
`else
   wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign rsp_err_o = 1'b0;
`endif

   // cyc and stb share one flop so they can never disagree
   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_stb_o = cyc_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;

   assign cmd_ready_o = !fifo_full;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_we_o    = rsp_we_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign busy_o      = !fifo_empty || (state != IDLE);

   // cycle sequencer: IDLE issues, REQ waits for ack, RESP holds result until taken
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state       <= IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_dat_q   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
         to_cnt      <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cyc_q <= 1'b1;
                  we_q  <= head_cmd.we;
                  adr_q <= head_cmd.adr;
                  dat_q <= head_cmd.dat;
`ifdef WB_MASTER_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                  state <= REQ;
               end
            end
            REQ: begin
               // ack is combinational on stb, so drop stb right after the ack cycle
               if (wb.wb_ack_i) begin
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_we_q    <= we_q;
                  rsp_dat_q   <= we_q ? '0 : wb.wb_dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
`endif
                  state       <= RESP;
               end
`ifdef WB_MASTER_TIMEOUT_EN
               else if (to_hit) begin
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_we_q    <= we_q;
                  rsp_dat_q   <= '0;
                  rsp_err_q   <= 1'b1;
                  state       <= RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
